seven_seg_scan_driver: RTL and testbench
========================================

# seven_seg_scan_driver

Time-multiplexed driver for a bank of common-anode/cathode seven-segment digits. It takes a packed hex word, per-digit decimal points and per-digit blank masks, and scans one digit at a time at a programmable rate. Updates are double-buffered so the display never tears mid-frame, and a dead-time window suppresses ghosting. It sits between register/debug logic and the board display pins.

## Interface
Parameters:
- DIGITS, 4: number of digits scanned (≥1).
- CLK_DIV, 50000: clock cycles per digit slot (≥ BLANK_CYCLES+1).
- BLANK_CYCLES, 2: all-off cycles at the start of every slot (≥0).
- ACTIVE_LOW, 1: 1 = o_seg/o_dp/o_an driven active-low; 0 = active-high.
- LZ_BLANK, 1: 1 = leading-zero suppression enabled.

Ports:
- i_clk  in  1  clock; single clock domain.
- i_rst  in  1  synchronous, active-high reset.
- i_data  in  4*DIGITS  hex nibbles; nibble k (bits 4k+3:4k) is digit k; digit 0 is rightmost.
- i_dp  in  DIGITS  decimal point per digit.
- i_blank  in  DIGITS  force digit k fully off (segments and dp).
- i_load  in  1  one-cycle strobe; captures i_data/i_dp/i_blank into shadow.
- o_seg  out  7  segments, bit0=a … bit6=g.
- o_dp  out  1  decimal point.
- o_an  out  DIGITS  digit enables, one-hot active (or all inactive).
- o_frame_tick  out  1  one-cycle pulse when digit DIGITS-1 slot ends.

## Operation
- Registers: slot counter cnt (0..CLK_DIV-1), digit index idx (0..DIGITS-1), shadow {data,dp,blank}+pending flag, active {data,dp,blank}.
- cnt increments each cycle; at CLK_DIV-1 wraps to 0 and idx advances; idx wraps DIGITS-1→0.
- Frame wrap = cycle where cnt==CLK_DIV-1 and idx==DIGITS-1: o_frame_tick pulses next cycle; if pending, shadow→active, pending cleared.
- i_load: shadow ← inputs, pending ← 1. Repeated loads within a frame overwrite; last one wins.
- i_load on the frame-wrap cycle: inputs go straight to active at that wrap; pending ends 0.
- Decode (internal active-high): 0→3F,1→06,2→5B,3→4F,4→66,5→6D,6→7D,7→07,8→7F,9→67,A→77,B→7C,C→39,D→5E,E→79,F→71.
- Leading-zero blank: digit k (k≥1) has segments off if its nibble and all higher nibbles are 0; dp still honoured. Digit 0 never LZ-blanked (0x0000 shows "0").
- i_blank[k]: segments and dp off for digit k; o_an still enabled.
- During dead-time (cnt < BLANK_CYCLES): o_an all inactive, o_seg/o_dp inactive.
- ACTIVE_LOW inverts all three output groups at the output register.

## Timing
- All outputs registered; they reflect cnt/idx/active of the previous cycle (latency 1).
- Reset: cnt=0, idx=0, shadow/active/pending=0, o_frame_tick=0, o_an/o_seg/o_dp inactive (ACTIVE_LOW=1: all ones).
- After reset release: BLANK_CYCLES cycles all off, then digit 0 enabled CLK_DIV-BLANK_CYCLES cycles; every slot exactly CLK_DIV cycles; frame DIGITS*CLK_DIV cycles.
- Active contents after reset are 0: display shows "0" on digit 0, others LZ-blanked (LZ_BLANK=1) until first load passes a frame wrap.
- Reset mid-slot: next cycle outputs inactive, pending load discarded, scan restarts at digit 0.
- DIGITS=1: idx fixed 0, every slot end is a frame wrap.

## Structure
- Shared display package: segment encoding constants (SEG_0..SEG_F, SEG_OFF), bit-order definition.
- Decode uses the team's existing hex-to-seven-segment decoder (N=4), one instance on the muxed nibble.
- One sub-module natural: seg_scan_timer (cnt/idx counters, dead-time flag, frame-wrap strobe).

## Test plan
Config DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2, ACTIVE_LOW=1 unless stated.
- Reset held 3 cycles → o_an=4'b1111, o_seg=7'h7F, o_dp=1, o_frame_tick=0; after release 2 off cycles, then o_an=4'b1110, o_seg=7'h40 ("0").
- LZ_BLANK=0, load 16'h12AF, wait a frame → digit0 o_seg=7'h0E, digit1 7'h08, digit2 7'h24, digit3 7'h79; o_an walks 1110→1101→1011→0111, each 6 cycles on/2 off.
- LZ_BLANK=1, load 16'h0005 with i_dp=4'b0100 → digits 3,1 o_seg=7'h7F, digit2 o_seg=7'h7F with o_dp=0, digit0 o_seg=7'h12.
- Load mid-frame → old value displayed until o_frame_tick; new value from next digit-0 slot; load exactly on frame-wrap cycle → new value in immediately following frame.
- i_blank=4'b0001, i_dp=4'b0001 → digit0 o_an active, o_seg=7'h7F, o_dp=1.
- Reset asserted at cnt=5 of digit 2 after pending load → outputs inactive next cycle, scan restarts digit 0, pending value never shown.

Source files
------------

// File: rtl/seven_seg_scan_driver_pkg.sv
// Shared display package for the seven-segment scan driver.
//   - Segment bit order: seg[0]=a, seg[1]=b, ... seg[6]=g (internal active-high).
//   - SEG_0..SEG_F : glyphs for hex digits, SEG_OFF : all segments dark.
//   - clog2_min1   : counter width helper that never returns zero.
package seven_seg_scan_driver_pkg;

   localparam int unsigned SEG_W = 7;
   typedef logic [SEG_W-1:0] seg_t;

   // Segment bit positions
   localparam int unsigned SEG_BIT_A = 0;
   localparam int unsigned SEG_BIT_G = 6;

   localparam seg_t SEG_0   = 7'h3F;
   localparam seg_t SEG_1   = 7'h06;
   localparam seg_t SEG_2   = 7'h5B;
   localparam seg_t SEG_3   = 7'h4F;
   localparam seg_t SEG_4   = 7'h66;
   localparam seg_t SEG_5   = 7'h6D;
   localparam seg_t SEG_6   = 7'h7D;
   localparam seg_t SEG_7   = 7'h07;
   localparam seg_t SEG_8   = 7'h7F;
   localparam seg_t SEG_9   = 7'h67;
   localparam seg_t SEG_A   = 7'h77;
   localparam seg_t SEG_B   = 7'h7C;
   localparam seg_t SEG_C   = 7'h39;
   localparam seg_t SEG_D   = 7'h5E;
   localparam seg_t SEG_E   = 7'h79;
   localparam seg_t SEG_F   = 7'h71;
   localparam seg_t SEG_OFF = 7'h00;

   // Width of a counter holding 0..v-1; at least one bit so v=1 still elaborates.
   function automatic int unsigned clog2_min1(input int unsigned v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

endpackage

// File: rtl/seven_seg_scan_driver_if.sv
// Display-content load bus for the seven-segment scan driver.
//   i_data  : 4*DIGITS hex nibbles, nibble k is digit k (digit 0 rightmost)
//   i_dp    : decimal point per digit
//   i_blank : force digit k fully dark
//   i_load  : one-cycle strobe capturing data/dp/blank into the shadow buffer
// Modports: master drives the bus (register/debug logic), slave is the driver.
interface seven_seg_scan_driver_if #(
   parameter int unsigned DIGITS = 4
);

   logic [4*DIGITS-1:0] i_data;
   logic [DIGITS-1:0]   i_dp;
   logic [DIGITS-1:0]   i_blank;
   logic                i_load;

   modport master (
      output i_data,
      output i_dp,
      output i_blank,
      output i_load
   );

   modport slave (
      input i_data,
      input i_dp,
      input i_blank,
      input i_load
   );

endinterface

// File: rtl/hex7seg_decoder.sv
// Hex-to-seven-segment decoder (combinational, active-high segments).
//   i_hex : N-bit hex value (N=4)
//   o_seg : segments, bit0=a .. bit6=g
module hex7seg_decoder
   import seven_seg_scan_driver_pkg::*;
#(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0] i_hex,
   output seg_t         o_seg
);

   always_comb begin
      o_seg = SEG_OFF;
      case (i_hex)
         4'h0:    o_seg = SEG_0;
         4'h1:    o_seg = SEG_1;
         4'h2:    o_seg = SEG_2;
         4'h3:    o_seg = SEG_3;
         4'h4:    o_seg = SEG_4;
         4'h5:    o_seg = SEG_5;
         4'h6:    o_seg = SEG_6;
         4'h7:    o_seg = SEG_7;
         4'h8:    o_seg = SEG_8;
         4'h9:    o_seg = SEG_9;
         4'hA:    o_seg = SEG_A;
         4'hB:    o_seg = SEG_B;
         4'hC:    o_seg = SEG_C;
         4'hD:    o_seg = SEG_D;
         4'hE:    o_seg = SEG_E;
         4'hF:    o_seg = SEG_F;
         default: o_seg = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/seven_seg_scan_driver_seg_scan_timer.sv
// Scan timing for the seven-segment driver.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   o_idx          : digit currently being scanned (0..DIGITS-1)
//   o_dead         : high during the all-off window at the start of each slot
//   o_frame_wrap   : high on the last cycle of the last digit's slot
module seven_seg_scan_driver_seg_scan_timer
   import seven_seg_scan_driver_pkg::*;
#(
   parameter int unsigned DIGITS       = 4,
   parameter int unsigned CLK_DIV      = 50000,
   parameter int unsigned BLANK_CYCLES = 2,
   localparam int unsigned CNT_W       = clog2_min1(CLK_DIV),
   localparam int unsigned IDX_W       = clog2_min1(DIGITS)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_dead,
   output logic             o_frame_wrap
);

   logic [CNT_W-1:0] cnt_q;
   logic [IDX_W-1:0] idx_q;
   logic             slot_end;
   logic             last_digit;

   assign slot_end   = (cnt_q == CNT_W'(CLK_DIV - 1));
   assign last_digit = (idx_q == IDX_W'(DIGITS - 1));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q <= '0;
         idx_q <= '0;
      end else if (slot_end) begin
         cnt_q <= '0;
         idx_q <= last_digit ? '0 : idx_q + IDX_W'(1);
      end else begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   // A zero-length dead window would make the compare constant-false.
   if (BLANK_CYCLES == 0) begin : g_no_dead
      assign o_dead = 1'b0;
   end else begin : g_dead
      assign o_dead = (cnt_q < CNT_W'(BLANK_CYCLES));
   end

   assign o_idx        = idx_q;
   assign o_frame_wrap = slot_end && last_digit;

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed seven-segment display driver with double-buffered contents.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus          : load bus (i_data, i_dp, i_blank, i_load), slave side
//   o_seg        : segments bit0=a .. bit6=g
//   o_dp         : decimal point
//   o_an         : digit enables, one-hot or all inactive
//   o_frame_tick : one-cycle pulse after the last digit's slot ends
// All outputs are registered; polarity selected by ACTIVE_LOW.
module seven_seg_scan_driver
   import seven_seg_scan_driver_pkg::*;
#(
   parameter int unsigned DIGITS       = 4,
   parameter int unsigned CLK_DIV      = 50000,
   parameter int unsigned BLANK_CYCLES = 2,
   parameter bit          ACTIVE_LOW   = 1'b1,
   parameter bit          LZ_BLANK     = 1'b1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   seven_seg_scan_driver_if.slave bus,
   output logic [SEG_W-1:0]      o_seg,
   output logic                  o_dp,
   output logic [DIGITS-1:0]     o_an,
   output logic                  o_frame_tick
);

   localparam int unsigned IDX_W = clog2_min1(DIGITS);

   logic [IDX_W-1:0] idx;
   logic             dead;
   logic             frame_wrap;

   seven_seg_scan_driver_seg_scan_timer #(
      .DIGITS       (DIGITS),
      .CLK_DIV      (CLK_DIV),
      .BLANK_CYCLES (BLANK_CYCLES)
   ) u_timer (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .o_idx        (idx),
      .o_dead       (dead),
      .o_frame_wrap (frame_wrap)
   );

   // Shadow / active display buffers
   logic [4*DIGITS-1:0] shadow_data_q, active_data_q;
   logic [DIGITS-1:0]   shadow_dp_q, active_dp_q;
   logic [DIGITS-1:0]   shadow_blank_q, active_blank_q;
   logic                pending_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         shadow_data_q  <= '0;
         shadow_dp_q    <= '0;
         shadow_blank_q <= '0;
         active_data_q  <= '0;
         active_dp_q    <= '0;
         active_blank_q <= '0;
         pending_q      <= 1'b0;
      end else begin
         if (bus.i_load) begin
            shadow_data_q  <= bus.i_data;
            shadow_dp_q    <= bus.i_dp;
            shadow_blank_q <= bus.i_blank;
         end
         if (frame_wrap) begin
            // A load coinciding with the wrap bypasses the shadow so it is not
            // held back a whole extra frame.
            if (bus.i_load) begin
               active_data_q  <= bus.i_data;
               active_dp_q    <= bus.i_dp;
               active_blank_q <= bus.i_blank;
            end else if (pending_q) begin
               active_data_q  <= shadow_data_q;
               active_dp_q    <= shadow_dp_q;
               active_blank_q <= shadow_blank_q;
            end
            pending_q <= 1'b0;
         end else if (bus.i_load) begin
            pending_q <= 1'b1;
         end
      end
   end

   // Leading-zero mask: lz[k] set when nibble k and every higher nibble are 0.
   // Digit 0 is never included so an all-zero word still shows "0".
   logic [DIGITS-1:0] lz;
   logic              upper_zero;

   always_comb begin
      lz         = '0;
      upper_zero = 1'b1;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         upper_zero = upper_zero && (active_data_q[4*k +: 4] == 4'h0);
         lz[k]      = upper_zero;
      end
   end

   logic [3:0] nibble;
   seg_t       dec_seg;

   assign nibble = active_data_q[{idx, 2'b00} +: 4];

   hex7seg_decoder #(
      .N     (4)
   ) u_dec (
      .i_hex (nibble),
      .o_seg (dec_seg)
   );

   // Next-state outputs, internal active-high
   seg_t              seg_d;
   logic              dp_d;
   logic [DIGITS-1:0] an_d;

   always_comb begin
      seg_d = SEG_OFF;
      dp_d  = 1'b0;
      an_d  = '0;
      if (!dead) begin
         an_d[idx] = 1'b1;
         if (!active_blank_q[idx]) begin
            dp_d = active_dp_q[idx];
            if (!(LZ_BLANK && lz[idx])) begin
               seg_d = dec_seg;
            end
         end
      end
   end

   logic [SEG_W-1:0]  seg_q;
   logic              dp_q;
   logic [DIGITS-1:0] an_q;
   logic              frame_tick_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         seg_q        <= {SEG_W{ACTIVE_LOW}};
         dp_q         <= ACTIVE_LOW;
         an_q         <= {DIGITS{ACTIVE_LOW}};
         frame_tick_q <= 1'b0;
      end else begin
         seg_q        <= seg_d ^ {SEG_W{ACTIVE_LOW}};
         dp_q         <= dp_d ^ ACTIVE_LOW;
         an_q         <= an_d ^ {DIGITS{ACTIVE_LOW}};
         frame_tick_q <= frame_wrap;
      end
   end

   assign o_seg        = seg_q;
   assign o_dp         = dp_q;
   assign o_an         = an_q;
   assign o_frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver: DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2,
// ACTIVE_LOW=1. Two instances share the load bus: dut (LZ_BLANK=1) and
// dut_nolz (LZ_BLANK=0). n counts rising edges since the last reset release;
// after edge n the outputs reflect scan position n-1 of the current run.
module tb_seven_seg_scan_driver;

   localparam int unsigned DIGITS = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   seven_seg_scan_driver_if #(.DIGITS(DIGITS)) bus ();

   logic [6:0]        seg, seg_nolz;
   logic              dp, dp_nolz;
   logic [DIGITS-1:0] an, an_nolz;
   logic              tick, tick_nolz;

   seven_seg_scan_driver #(
      .DIGITS       (DIGITS),
      .CLK_DIV      (8),
      .BLANK_CYCLES (2),
      .ACTIVE_LOW   (1'b1),
      .LZ_BLANK     (1'b1)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .bus          (bus),
      .o_seg        (seg),
      .o_dp         (dp),
      .o_an         (an),
      .o_frame_tick (tick)
   );

   seven_seg_scan_driver #(
      .DIGITS       (DIGITS),
      .CLK_DIV      (8),
      .BLANK_CYCLES (2),
      .ACTIVE_LOW   (1'b1),
      .LZ_BLANK     (1'b0)
   ) dut_nolz (
      .i_clk        (clk),
      .i_rst        (rst),
      .bus          (bus),
      .o_seg        (seg_nolz),
      .o_dp         (dp_nolz),
      .o_an         (an_nolz),
      .o_frame_tick (tick_nolz)
   );

   int n        = 0;
   int vectors  = 0;
   int errors   = 0;

   task automatic step_to(input int target);
      while (n < target) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s (n=%0d): observed %h expected %h", tag, n, obs, exp);
      end
   endtask

   task automatic load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
      bus.i_data  = d;
      bus.i_dp    = p;
      bus.i_blank = b;
      bus.i_load  = 1'b1;
      step_to(n + 1);
      bus.i_load  = 1'b0;
   endtask

   initial begin
      bus.i_data  = '0;
      bus.i_dp    = '0;
      bus.i_blank = '0;
      bus.i_load  = 1'b0;

      // Reset held for 3 cycles
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      chk("rst_an",   32'(an),   32'hF);
      chk("rst_seg",  32'(seg),  32'h7F);
      chk("rst_dp",   32'(dp),   32'h1);
      chk("rst_tick", 32'(tick), 32'h0);
      rst = 1'b0;
      n   = 0;

      // Two dead cycles, then digit 0 shows "0"
      step_to(1);  chk("dead1_an", 32'(an), 32'hF);
      step_to(2);  chk("dead2_an", 32'(an), 32'hF);
      step_to(3);
      chk("d0_an",       32'(an),       32'hE);
      chk("d0_seg",      32'(seg),      32'h40);
      chk("d0_dp",       32'(dp),       32'h1);
      chk("d0_nolz_seg", 32'(seg_nolz), 32'h40);

      // Mid-frame load of 12AF: stays pending until the frame wrap
      load(16'h12AF, 4'b0000, 4'b0000);                 // sampled at position 3
      step_to(11);
      chk("old_d1_an",       32'(an),       32'hD);
      chk("old_d1_seg_lz",   32'(seg),      32'h7F);
      chk("old_d1_seg_nolz", 32'(seg_nolz), 32'h40);
      step_to(31); chk("tick_before", 32'(tick), 32'h0);
      step_to(32); chk("tick_pulse",  32'(tick), 32'h1);
      step_to(33); chk("tick_after",  32'(tick), 32'h0);

      // Frame showing 12AF: o_an walk with 6 on / 2 off per slot
      step_to(35);
      chk("f1_d0_an",  32'(an_nolz),  32'hE);
      chk("f1_d0_seg", 32'(seg_nolz), 32'h0E);
      chk("f1_d0_seg_lz", 32'(seg),   32'h0E);
      step_to(40); chk("f1_d0_last_an", 32'(an_nolz), 32'hE);
      step_to(41); chk("f1_d1_dead_an", 32'(an_nolz), 32'hF);
      step_to(42); chk("f1_d1_dead2",   32'(an_nolz), 32'hF);
      step_to(43);
      chk("f1_d1_an",  32'(an_nolz),  32'hD);
      chk("f1_d1_seg", 32'(seg_nolz), 32'h08);
      step_to(51);
      chk("f1_d2_an",  32'(an_nolz),  32'hB);
      chk("f1_d2_seg", 32'(seg_nolz), 32'h24);
      step_to(59);
      chk("f1_d3_an",  32'(an_nolz),  32'h7);
      chk("f1_d3_seg", 32'(seg_nolz), 32'h79);

      // Load 0005 with dp on digit 2, sampled exactly on the frame-wrap cycle
      step_to(63);
      load(16'h0005, 4'b0100, 4'b0000);                 // sampled at position 63
      step_to(67);
      chk("f2_d0_an",  32'(an),  32'hE);
      chk("f2_d0_seg", 32'(seg), 32'h12);
      chk("f2_d0_dp",  32'(dp),  32'h1);

      // Mid-frame load with blank/dp on digit 0: pending until next wrap
      step_to(70);
      load(16'h0005, 4'b0001, 4'b0001);                 // sampled at position 70
      step_to(75);
      chk("f2_d1_an",       32'(an),       32'hD);
      chk("f2_d1_seg",      32'(seg),      32'h7F);
      chk("f2_d1_nolz_seg", 32'(seg_nolz), 32'h40);
      step_to(83);
      chk("f2_d2_an",  32'(an),  32'hB);
      chk("f2_d2_seg", 32'(seg), 32'h7F);
      chk("f2_d2_dp",  32'(dp),  32'h0);
      step_to(91);
      chk("f2_d3_an",  32'(an),  32'h7);
      chk("f2_d3_seg", 32'(seg), 32'h7F);
      chk("f2_d3_dp",  32'(dp),  32'h1);

      // Blanked digit 0: enabled but dark, dp suppressed
      step_to(99);
      chk("blank_d0_an",  32'(an),  32'hE);
      chk("blank_d0_seg", 32'(seg), 32'h7F);
      chk("blank_d0_dp",  32'(dp),  32'h1);

      // Pending load then reset at cnt=5 of digit 2
      step_to(100);
      load(16'h0088, 4'b0000, 4'b0000);                 // sampled at position 100
      step_to(117);
      chk("pre_rst_an", 32'(an), 32'hB);
      rst = 1'b1;                                        // sampled at position 117
      step_to(118);
      chk("midrst_an",   32'(an),   32'hF);
      chk("midrst_seg",  32'(seg),  32'h7F);
      chk("midrst_dp",   32'(dp),   32'h1);
      chk("midrst_tick", 32'(tick), 32'h0);
      rst = 1'b0;
      n   = 0;
      step_to(2);  chk("re_dead_an", 32'(an), 32'hF);
      step_to(3);
      chk("re_d0_an",  32'(an),  32'hE);
      chk("re_d0_seg", 32'(seg), 32'h40);
      chk("re_d0_dp",  32'(dp),  32'h1);
      step_to(32); chk("re_tick", 32'(tick), 32'h1);
      step_to(35);
      chk("re_f1_d0_an",  32'(an),  32'hE);
      chk("re_f1_d0_seg", 32'(seg), 32'h40);
      step_to(43);
      chk("re_f1_d1_an",  32'(an),  32'hD);
      chk("re_f1_d1_seg", 32'(seg), 32'h7F);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
